// File: rtl/dejdr_pkg.sv
// Shared types, lookups and helpers for the multi-dice roller.
// Die-type enum, faces table, 7-segment codes, LFSR taps, FSM states.
package dejdr_pkg;

    typedef enum logic [2:0] {
        DT_D4   = 3'd0,
        DT_D6   = 3'd1,
        DT_D8   = 3'd2,
        DT_D10  = 3'd3,
        DT_D12  = 3'd4,
        DT_D20  = 3'd5,
        DT_D100 = 3'd6
    } die_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROLL = 3'd1,
        ST_SUM  = 3'd2,
        ST_CONV = 3'd3,
        ST_SHOW = 3'd4
    } state_t;

    localparam int          LFSR_W    = 16;
    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Active-low segments, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] faces(input die_t t);
        unique case (t)
            DT_D4:   return 7'd4;
            DT_D6:   return 7'd6;
            DT_D8:   return 7'd8;
            DT_D10:  return 7'd10;
            DT_D12:  return 7'd12;
            DT_D20:  return 7'd20;
            DT_D100: return 7'd100;
            default: return 7'd6;
        endcase
    endfunction

    function automatic die_t next_die(input die_t t);
        if (t == DT_D100)
            return DT_D4;
        return die_t'(t + 3'd1);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        unique case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Values here never exceed 100, so a single hundreds check suffices
    function automatic logic [11:0] to_bcd3(input logic [6:0] v);
        logic [6:0] r;
        logic [3:0] h;
        h = (v >= 7'd100) ? 4'd1 : 4'd0;
        r = (v >= 7'd100) ? v - 7'd100 : v;
        return {h, 4'(r / 7'd10), 4'(r % 7'd10)};
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] l
    );
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dejdr_bin2bcd.sv
// Iterative double-dabble: start loads bin, done pulses SUM_W cycles later.
// Ports: clk, rst_n, start, bin -> done, d100, d10, d1 (BCD digits).
module dejdr_bin2bcd #(
    parameter int SUM_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] bin,
    output logic             done,
    output logic [3:0]       d100,
    output logic [3:0]       d10,
    output logic [3:0]       d1
);

    localparam int IT_W = $clog2(SUM_W + 1);

    logic [SUM_W-1:0] sr_q;
    logic [11:0]      bcd_q;
    logic [11:0]      dab;
    logic [IT_W-1:0]  it_q;
    logic             act_q;

    // add-3 on every nibble of 5 or more before each shift
    always_comb begin
        dab = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                dab[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            bcd_q <= '0;
            it_q  <= '0;
            act_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr_q  <= bin;
                bcd_q <= '0;
                it_q  <= IT_W'(SUM_W);
                act_q <= 1'b1;
            end else if (act_q) begin
                {bcd_q, sr_q} <= {dab, sr_q} << 1;
                it_q          <= it_q - IT_W'(1);
                if (it_q == IT_W'(1)) begin
                    act_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign d100 = bcd_q[11:8];
    assign d10  = bcd_q[7:4];
    assign d1   = bcd_q[3:0];

endmodule

// File: rtl/de_jdr_multi.sv
// Multi-dice RPG roller: debounced buttons, roll FSM, summed 3-digit result.
// In: clk, rst_n, suivant_n/nombre_n/lancer_n (low = pressed).
// Out: typ_d/typ100/typ10/typ1 die type, nb count, res100/res10/res1, busy.
// Option DEJDR_CRIT_EN adds crit (critical on max, blink on fumble).
module de_jdr_multi
    import dejdr_pkg::*;
#(
    parameter int          NB_DES_MAX      = 4,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       suivant_n,
    input  logic       nombre_n,
    input  logic       lancer_n,
    output logic [6:0] typ_d,
    output logic [6:0] typ100,
    output logic [6:0] typ10,
    output logic [6:0] typ1,
    output logic [6:0] nb,
    output logic [6:0] res100,
    output logic [6:0] res10,
    output logic [6:0] res1,
    output logic       busy
`ifdef DEJDR_CRIT_EN
    ,
    output logic       crit
`endif
);

    localparam int SUM_W = $clog2(NB_DES_MAX * 100 + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    // bit0 = suivant, bit1 = nombre, bit2 = lancer
    logic [2:0] btn_n;
    logic [2:0] level;
    logic [2:0] press;
    logic       unused_lvl;

    assign btn_n      = {lancer_n, nombre_n, suivant_n};
    assign unused_lvl = ^level[1:0];

    for (genvar g = 0; g < 3; g++) begin : g_db
        logic            s1_q;
        logic            s2_q;
        logic            lvl_q;
        logic            prs_q;
        logic [DB_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q  <= 1'b1;
                s2_q  <= 1'b1;
                lvl_q <= 1'b1;
                prs_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q  <= btn_n[g];
                s2_q  <= s1_q;
                prs_q <= 1'b0;
                if (s2_q == lvl_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_MAX) begin
                    cnt_q <= '0;
                    lvl_q <= s2_q;
                    prs_q <= ~s2_q;
                end else begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
            end
        end

        assign level[g] = lvl_q;
        assign press[g] = prs_q;
    end

    state_t            state_q;
    state_t            state_d;
    die_t              typ_q;
    logic [3:0]        cnt_q;
    logic [3:0]        k_q;
    logic [SUM_W-1:0]  acc_q;
    logic [SUM_W-1:0]  acc_next;
    logic [LFSR_W-1:0] lfsr_q;
    logic [15:0]       anim_q;
    logic [6:0]        die_val;
    logic [11:0]       die_bcd;
    logic [11:0]       typ_bcd;

    logic adv_typ;
    logic adv_nb;
    logic clr_acc;
    logic add_die;
    logic bcd_start;
    logic latch_res;
    logic anim_ld;

    logic       bcd_done;
    logic [3:0] b100;
    logic [3:0] b10;
    logic [3:0] b1;

    // Scale the 16-bit LFSR onto 1..faces
    assign die_val  = 7'(({7'd0, lfsr_q} * {16'd0, faces(typ_q)}) >> 16)
                    + 7'd1;
    assign die_bcd  = to_bcd3(die_val);
    assign acc_next = acc_q + SUM_W'(die_val);

    always_comb begin
        state_d   = state_q;
        adv_typ   = 1'b0;
        adv_nb    = 1'b0;
        clr_acc   = 1'b0;
        add_die   = 1'b0;
        bcd_start = 1'b0;
        latch_res = 1'b0;
        anim_ld   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_SHOW: begin
                adv_typ = press[0];
                adv_nb  = press[1];
                if (press[2])
                    state_d = ST_ROLL;
            end
            ST_ROLL: begin
                anim_ld = (anim_q == '0);
                if (level[2]) begin
                    state_d = ST_SUM;
                    clr_acc = 1'b1;
                end
            end
            ST_SUM: begin
                add_die = 1'b1;
                // last die goes straight into the converter via acc_next
                if (k_q + 4'd1 == cnt_q) begin
                    bcd_start = 1'b1;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                if (bcd_done) begin
                    latch_res = 1'b1;
                    state_d   = ST_SHOW;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            typ_q  <= DT_D6;
            cnt_q  <= 4'd1;
            k_q    <= '0;
            acc_q  <= '0;
            lfsr_q <= SEED;
            anim_q <= '0;
            res100 <= SEG_BLANK;
            res10  <= SEG_BLANK;
            res1   <= SEG_BLANK;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            anim_q <= anim_q + 16'd1;
            if (adv_typ)
                typ_q <= next_die(typ_q);
            if (adv_nb)
                cnt_q <= (cnt_q == 4'(NB_DES_MAX)) ? 4'd1 : cnt_q + 4'd1;
            if (clr_acc) begin
                acc_q <= '0;
                k_q   <= '0;
            end else if (add_die) begin
                acc_q <= acc_next;
                k_q   <= k_q + 4'd1;
            end
            if (anim_ld) begin
                res100 <= seg7(die_bcd[11:8]);
                res10  <= seg7(die_bcd[7:4]);
                res1   <= seg7(die_bcd[3:0]);
            end
            if (latch_res) begin
                res100 <= seg7(b100);
                res10  <= seg7(b10);
                res1   <= seg7(b1);
            end
        end
    end

    dejdr_bin2bcd #(
        .SUM_W(SUM_W)
    ) u_bcd (
        .clk  (clk),
        .rst_n(rst_n),
        .start(bcd_start),
        .bin  (acc_next),
        .done (bcd_done),
        .d100 (b100),
        .d10  (b10),
        .d1   (b1)
    );

    assign busy = (state_q == ST_ROLL) || (state_q == ST_SUM)
               || (state_q == ST_CONV);

    // Faces shown with leading zeros blanked
    assign typ_bcd = to_bcd3(faces(typ_q));
    assign typ_d   = SEG_D;
    assign typ100  = (typ_bcd[11:8] == 4'd0) ? SEG_BLANK
                                            : seg7(typ_bcd[11:8]);
    assign typ10   = (typ_bcd[11:4] == 8'd0) ? SEG_BLANK
                                            : seg7(typ_bcd[7:4]);
    assign typ1    = seg7(typ_bcd[3:0]);
    assign nb      = seg7(cnt_q);

`ifdef DEJDR_CRIT_EN
    logic [21:0] blink_q;
    logic        crit_max_q;
    logic        crit_min_q;

    // Flags are captured with the result so later type changes keep them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q    <= '0;
            crit_max_q <= 1'b0;
            crit_min_q <= 1'b0;
        end else begin
            blink_q <= blink_q + 22'd1;
            if (latch_res) begin
                crit_max_q <= (cnt_q == 4'd1)
                           && (acc_q == SUM_W'(faces(typ_q)));
                crit_min_q <= (cnt_q == 4'd1)
                           && (acc_q == SUM_W'(1));
            end
        end
    end

    assign crit = (state_q == ST_SHOW)
               && (crit_max_q || (crit_min_q && blink_q[21]));
`endif

endmodule

// File: tb/tb_de_jdr_multi.sv
// Randomised bench for de_jdr_multi against a behavioural dice model.
// Shadow LFSR history gives the draws the roll must have summed.
module tb_de_jdr_multi;

    localparam int          NB   = 4;
    localparam int          DEB  = 16;
    localparam int          SUMW = $clog2(NB * 100 + 1);
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [6:0]  BL   = 7'h7F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       suivant_n = 1'b1;
    logic       nombre_n = 1'b1;
    logic       lancer_n = 1'b1;
    logic [6:0] typ_d, typ100, typ10, typ1, nb;
    logic [6:0] res100, res10, res1;
    logic       busy;
`ifdef DEJDR_CRIT_EN
    logic       crit;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int m_t;
    int m_n;
    int last_sum;
    int cyc = 0;
    int fc [0:6] = '{4, 6, 8, 10, 12, 20, 100};
    logic [15:0] sh;
    logic [15:0] hist [0:65535];

    always #5 clk = ~clk;

    de_jdr_multi #(
        .NB_DES_MAX(NB),
        .DEBOUNCE_CYCLES(DEB),
        .SEED(SEED)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .suivant_n(suivant_n),
        .nombre_n(nombre_n),
        .lancer_n(lancer_n),
        .typ_d(typ_d),
        .typ100(typ100),
        .typ10(typ10),
        .typ1(typ1),
        .nb(nb),
        .res100(res100),
        .res10(res10),
        .res1(res1),
        .busy(busy)
`ifdef DEJDR_CRIT_EN
        ,
        .crit(crit)
`endif
    );

    // x^16+x^14+x^13+x^11+1 generator, one step per clock from SEED
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sh <= SEED;
        else
            sh <= {sh[14:0], sh[15] ^ sh[13] ^ sh[12] ^ sh[10]};
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) hist[cyc % 65536] = sh;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] seg(input int d);
        logic [6:0] on;
        case (d)
            0: on = 7'b0111111;
            1: on = 7'b0000110;
            2: on = 7'b1011011;
            3: on = 7'b1001111;
            4: on = 7'b1100110;
            5: on = 7'b1101101;
            6: on = 7'b1111101;
            7: on = 7'b0000111;
            8: on = 7'b1111111;
            9: on = 7'b1101111;
            default: on = 7'b0000000;
        endcase
        return ~on;
    endfunction

    function automatic logic [27:0] exp_typ(input int f);
        int h, t;
        logic [6:0] sh_, st_;
        h = f / 100;
        t = (f / 10) % 10;
        sh_ = (h == 0) ? BL : seg(h);
        st_ = (h == 0 && t == 0) ? BL : seg(t);
        return {~7'b1011110, sh_, st_, seg(f % 10)};
    endfunction

    function automatic logic [20:0] exp_res(input int s);
        return {seg((s / 100) % 10), seg((s / 10) % 10), seg(s % 10)};
    endfunction

    task automatic check_disp(input string tag);
        check({tag, " typ"}, {typ_d, typ100, typ10, typ1},
              exp_typ(fc[m_t]));
        check({tag, " nb"}, nb, seg(m_n));
    endtask

    task automatic press(input bit s, input bit n);
        @(negedge clk);
        suivant_n = !s;
        nombre_n  = !n;
        repeat (DEB + 4) @(negedge clk);
        suivant_n = 1'b1;
        nombre_n  = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        if (s) m_t = (m_t + 1) % 7;
        if (n) m_n = (m_n % NB) + 1;
    endtask

    task automatic do_roll(input int hold);
        int n0, lat, s, f, d, idx;
        @(negedge clk);
        lancer_n = 1'b0;
        repeat (hold) @(negedge clk);
        check("roll busy", busy, 1);
        lancer_n = 1'b1;
        n0 = cyc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        lat = cyc - n0;
        check("roll latency", lat, DEB + 2 + m_n + SUMW + 2);
        f = fc[m_t];
        s = 0;
        for (int j = 0; j < m_n; j++) begin
            idx = (n0 + DEB + 3 + j) % 65536;
            d = (int'(hist[idx]) * f) / 65536 + 1;
            s += d;
        end
        last_sum = s;
        check("roll result", {res100, res10, res1}, exp_res(s));
`ifdef DEJDR_CRIT_EN
        if (m_n == 1 && s == f)
            check("crit max", crit, 1);
        else if (s != 1)
            check("crit off", crit, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int ns;
        int nn;
        m_t = 1;
        m_n = 1;
        last_sum = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check_disp("reset");
        check("reset res", {res100, res10, res1}, {BL, BL, BL});
        check("reset busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            press(1, 0);
            check("suivant typ", {typ_d, typ100, typ10, typ1},
                  exp_typ(fc[m_t]));
        end

        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            lancer_n = 1'b0;
            repeat ((g == 0) ? 3 : DEB - 2) @(negedge clk);
            lancer_n = 1'b1;
            repeat (DEB + 6) @(negedge clk);
            check("glitch busy", busy, 0);
            check("glitch res", {res100, res10, res1}, {BL, BL, BL});
        end
        check_disp("glitch");

        repeat (5) press(1, 0);
        repeat (3) press(0, 1);
        check_disp("d100x4");
        do_roll(50);

        for (int i = 0; i < NB; i++) begin
            press(0, 1);
            check("nombre wrap", nb, seg(m_n));
        end
        press(1, 1);
        check_disp("both");
        check("show kept", {res100, res10, res1}, exp_res(last_sum));

        for (int r = 0; r < 6; r++) begin
            ns = $urandom_range(6, 0);
            nn = $urandom_range(3, 0);
            for (int i = 0; i < ns; i++) press(1, 0);
            for (int i = 0; i < nn; i++) press(0, 1);
            check_disp("rnd");
            do_roll($urandom_range(DEB + 40, DEB + 6));
        end

        @(negedge clk);
        lancer_n = 1'b0;
        repeat (40) @(negedge clk);
        lancer_n = 1'b1;
        n0 = cyc;
        repeat (DEB + 3) @(negedge clk);
        check("sum busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        m_t = 1;
        m_n = 1;
        check_disp("midreset");
        check("midreset res", {res100, res10, res1}, {BL, BL, BL});
        check("midreset busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        do_roll(30);
        press(1, 1);
        check_disp("post");
        do_roll(DEB + 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
